// File: rtl/logistic_bank.sv
// -----------------------------------------------------------------------------
// logistic_bank
//
// Multi-channel iterator for the fixed-point logistic map
//   x(n+1) = 4 * x(n) * (1 - x(n))
// with x held as an unsigned Q0.W fraction in [0,1). CHANNELS independent
// states are kept in registers. A run advances every channel N times,
// issuing channels round-robin into a two-stage pipeline:
//   stage 1 : read channel state, form the 2W-bit product, register it
//   stage 2 : apply the fixed-point escapes, write the state back and
//             present the new value on the output registers
//
// Handshake summary: there is no backpressure. start is a one-cycle request
// that is honoured only in IDLE. out_valid is a one-cycle qualifier for
// out_ch/out_data, and the consumer must take the value in that cycle.
// done pulses once per accepted start, together with the last out_valid of
// the run or alone when no result is pending.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   seed_we/seed_ch/seed_data
//                           seed write, ignored while busy
//   start, iter_count       begin a run of iter_count iterations per channel
//   abort                   stop issuing, drain in-flight results, finish
//   busy                    run in progress (RUN or DRAIN)
//   out_valid/out_ch/out_data
//                           freshly computed state and its channel
//   done                    one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module logistic_bank #(
    parameter  int W        = 32,
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 16,
    parameter  int ZERO_SUB = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_we,
    input  logic [CH_W-1:0]  seed_ch,
    input  logic [W-1:0]     seed_data,
    input  logic             start,
    input  logic [CNT_W-1:0] iter_count,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [W-1:0]     out_data,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Classification of the issued value, resolved in stage 2.
    typedef enum logic [1:0] {
        K_NORMAL = 2'd0,
        K_ZERO   = 2'd1,
        K_HALF   = 2'd2,
        K_3Q     = 2'd3
    } kind_t;

    localparam logic [W-1:0]     X_HALF   = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     X_3Q     = {2'b11, {(W-2){1'b0}}};
    localparam logic [W-1:0]     ZERO_V   = W'(ZERO_SUB);
    localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // ---------------------------------------------------------------- state
    state_t           state_q,      state_d;
    logic [CH_W-1:0]  ch_q,         ch_d;
    logic [CNT_W-1:0] rounds_q,     rounds_d;
    logic             phase_q,      phase_d;

    logic             s1_valid_q,   s1_valid_d;
    logic [CH_W-1:0]  s1_ch_q,      s1_ch_d;
    logic [W-1:0]     s1_mid_q,     s1_mid_d;
    kind_t            s1_kind_q,    s1_kind_d;

    logic [W-1:0]     st_q [CHANNELS];
    logic [W-1:0]     st_d [CHANNELS];

    logic             busy_q,       busy_d;
    logic             out_valid_q,  out_valid_d;
    logic [CH_W-1:0]  out_ch_q,     out_ch_d;
    logic [W-1:0]     out_data_q,   out_data_d;
    logic             done_q,       done_d;

    // ------------------------------------------------------ stage 1 (issue)
    logic             issue;
    logic [W-1:0]     issue_x;
    logic [W-1:0]     issue_neg;
    logic [2*W-1:0]   issue_prod;

    // With a single channel the same state is read back-to-back, so every
    // other RUN cycle is left empty to let the previous result land first.
    always_comb begin
        issue = (state_q == S_RUN) && ((CHANNELS > 1) || !phase_q);
    end

    always_comb begin
        issue_x = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_q == CH_W'(i)) begin
                issue_x = st_q[i];
            end
        end
        // (2^W - x) mod 2^W is the two's complement of x
        issue_neg  = '0 - issue_x;
        issue_prod = {{W{1'b0}}, issue_x} * {{W{1'b0}}, issue_neg};
    end

    always_comb begin
        s1_valid_d = issue;
        s1_ch_d    = issue ? ch_q : s1_ch_q;
        // p[2W-3:W-2]; p[2W-2] is always 0 because x*(1-x) <= 1/4.
        s1_mid_d   = issue ? W'(issue_prod >> (W - 2)) : s1_mid_q;
        s1_kind_d  = s1_kind_q;
        if (issue) begin
            if (issue_x == '0) begin
                s1_kind_d = K_ZERO;
            end else if (issue_x == X_HALF) begin
                s1_kind_d = K_HALF;
            end else if (issue_x == X_3Q) begin
                s1_kind_d = K_3Q;
            end else begin
                s1_kind_d = K_NORMAL;
            end
        end
    end

    // ----------------------------------------------- stage 2 (map, write)
    logic [W-1:0] map_y;

    // 0 and 0.75 are fixed points of the map and 0.5 maps to 1.0, which is
    // not representable; all three are nudged to keep the sequence alive.
    always_comb begin
        unique case (s1_kind_q)
            K_ZERO:  map_y = ZERO_V;
            K_HALF:  map_y = ALL_ONES;
            K_3Q:    map_y = X_3Q - W'(1);
            default: map_y = s1_mid_q;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i] = st_q[i];
        end
        out_valid_d = s1_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;

        if (s1_valid_q) begin
            out_ch_d   = s1_ch_q;
            out_data_d = map_y;
            for (int i = 0; i < CHANNELS; i++) begin
                if (s1_ch_q == CH_W'(i)) begin
                    st_d[i] = map_y;
                end
            end
        end

        // Seeds only land while idle, so they never race a write-back.
        if (seed_we && !busy_q) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (seed_ch == CH_W'(i)) begin
                    st_d[i] = seed_data;
                end
            end
        end
    end

    // ------------------------------------------------------------ control
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rounds_d = rounds_q;
        phase_d  = phase_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (iter_count != '0) begin
                        state_d  = S_RUN;
                        rounds_d = iter_count;
                        ch_d     = '0;
                        phase_d  = 1'b0;
                    end else begin
                        // Empty run: acknowledge without ever going busy.
                        done_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                phase_d = (CHANNELS == 1) ? !phase_q : 1'b0;
                if (issue) begin
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        if (rounds_q == ONE_CNT) begin
                            state_d = S_DRAIN;
                        end else begin
                            rounds_d = rounds_q - ONE_CNT;
                        end
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end
                // The issue in the abort cycle still goes ahead; nothing after.
                if (abort) begin
                    state_d = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Stage 2 retires one result per cycle and nothing is issued
                // here, so by the end of the first DRAIN cycle the last result
                // is being written: done lines up with that out_valid.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------- flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            rounds_q    <= '0;
            phase_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ch_q     <= '0;
            s1_mid_q    <= '0;
            s1_kind_q   <= K_NORMAL;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i] <= '0;
            end
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rounds_q    <= rounds_d;
            phase_q     <= phase_d;
            s1_valid_q  <= s1_valid_d;
            s1_ch_q     <= s1_ch_d;
            s1_mid_q    <= s1_mid_d;
            s1_kind_q   <= s1_kind_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i] <= st_d[i];
            end
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule
